// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- 32-bit ALU operation sequencer over an external 16-bit ALU.
//
// Accepts one request (ADD32 / SUB32 / AND32 / XOR32) through a valid/ready
// handshake, runs it as two 16-bit passes through an external combinational
// ALU (low half, then high half with carry chained), then holds the result
// until the consumer takes it.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_op[1:0]            00 ADD32, 01 SUB32, 10 AND32, 11 XOR32
//   req_a, req_b [31:0]    operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_data[31:0]         result
//   rsp_carry              carry out of bit 31 (SUB32: 1 = no borrow)
//   alu_enable, alu_sel    external ALU enable and select (0000/0011/0100)
//   alu_a, alu_b, alu_c    external ALU operand words and carry-in
//   alu_res, alu_cout      external ALU result and carry-out
//   rsp_ovf                signed overflow (only with ALU_SEQ_OVF_EN)
//
// Build option: define ALU_SEQ_OVF_EN to add the rsp_ovf output.
// -----------------------------------------------------------------------------
module alu_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_carry,
   output logic        alu_enable,
   output logic [3:0]  alu_sel,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_c,
   input  logic [15:0] alu_res,
   input  logic        alu_cout
`ifdef ALU_SEQ_OVF_EN
   ,output logic       rsp_ovf
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic        carry_q, carry_d;
`ifdef ALU_SEQ_OVF_EN
   logic        ovf_q, ovf_d;
`endif

   logic [31:0] b_eff;    // b' : inverted for SUB32 (two's complement with carry-in 1)
   logic        is_arith;
   logic [3:0]  op_sel;

   always_comb begin
      b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
      is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
      unique case (op_q)
         OP_AND:  op_sel = 4'b0011;
         OP_XOR:  op_sel = 4'b0100;
         default: op_sel = 4'b0000;
      endcase
   end

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      carry_d    = carry_q;
`ifdef ALU_SEQ_OVF_EN
      ovf_d      = ovf_q;
`endif
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      alu_enable = 1'b0;
      alu_sel    = 4'b0000;
      alu_a      = 16'h0000;
      alu_b      = 16'h0000;
      alu_c      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = op_e'(req_op);
               a_d     = req_a;
               b_d     = req_b;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            alu_enable   = 1'b1;
            alu_sel      = op_sel;
            alu_a        = a_q[15:0];
            alu_b        = b_eff[15:0];
            alu_c        = (op_q == OP_SUB);
            res_d[15:0]  = alu_res;
            carry_d      = alu_cout;
            state_d      = ST_HI;
         end
         ST_HI: begin
            alu_enable    = 1'b1;
            alu_sel       = op_sel;
            alu_a         = a_q[31:16];
            alu_b         = b_eff[31:16];
            // Logic ops must not see a stale low-half carry.
            alu_c         = is_arith & carry_q;
            res_d[31:16]  = alu_res;
            carry_d       = is_arith & alu_cout;
`ifdef ALU_SEQ_OVF_EN
            // a31 ^ b'31 ^ sum31 recovers the carry into bit 31; overflow is that XOR carry-out.
            ovf_d         = is_arith & (a_q[31] ^ b_eff[31] ^ alu_res[15] ^ alu_cout);
`endif
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers of these flops.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: all operand/result registers are few and must read 0 in reset, so every flop is reset.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
`ifdef ALU_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign rsp_data  = res_q;
   assign rsp_carry = carry_q;
`ifdef ALU_SEQ_OVF_EN
   assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq. Provides a
// behavioural 16-bit ALU on the alu_* interface and checks each step of
// hand-computed transactions, response hold-off and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_carry;
   logic        alu_enable;
   logic [3:0]  alu_sel;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_c;
   logic [15:0] alu_res;
   logic        alu_cout;
`ifdef ALU_SEQ_OVF_EN
   logic        rsp_ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_carry  (rsp_carry),
      .alu_enable (alu_enable),
      .alu_sel    (alu_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_c      (alu_c),
      .alu_res    (alu_res),
      .alu_cout   (alu_cout)
`ifdef ALU_SEQ_OVF_EN
      ,.rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural external 16-bit ALU.
   always_comb begin
      alu_res  = 16'h0000;
      alu_cout = 1'b0;
      case (alu_sel)
         4'b0000: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_c};
         4'b0011: alu_res = alu_a & alu_b;
         4'b0100: alu_res = alu_a ^ alu_b;
         default: alu_res = 16'h0000;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_alu_idle(input string tag);
      check({tag, "_alu_en"},  {31'd0, alu_enable}, 32'd0);
      check({tag, "_alu_sel"}, {28'd0, alu_sel},    32'd0);
      check({tag, "_alu_a"},   {16'd0, alu_a},      32'd0);
      check({tag, "_alu_b"},   {16'd0, alu_b},      32'd0);
      check({tag, "_alu_c"},   {31'd0, alu_c},      32'd0);
   endtask

   // Runs one transaction; hold = cycles to keep rsp_ready low in RESP.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data,
                         input logic exp_carry, input logic exp_ovf, input int hold);
      logic [31:0] bp;
      logic [16:0] lo_sum;
      logic        arith;
      logic [3:0]  sel;
      arith  = (op == 2'b00) || (op == 2'b01);
      bp     = (op == 2'b01) ? ~b : b;
      sel    = (op == 2'b10) ? 4'b0011 : (op == 2'b11) ? 4'b0100 : 4'b0000;
      lo_sum = {1'b0, a[15:0]} + {1'b0, bp[15:0]} + {16'd0, op == 2'b01};

      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      // Scramble request inputs: in-flight operation must not notice.
      req_valid = 1'b0;
      req_op    = ~op;
      req_a     = ~a;
      req_b     = a;
      check({tag, "_lo_ready"}, {31'd0, req_ready},  32'd0);
      check({tag, "_lo_en"},    {31'd0, alu_enable}, 32'd1);
      check({tag, "_lo_sel"},   {28'd0, alu_sel},    {28'd0, sel});
      check({tag, "_lo_a"},     {16'd0, alu_a},      {16'd0, a[15:0]});
      check({tag, "_lo_b"},     {16'd0, alu_b},      {16'd0, bp[15:0]});
      check({tag, "_lo_c"},     {31'd0, alu_c},      {31'd0, op == 2'b01});
      tick();
      check({tag, "_hi_en"},    {31'd0, alu_enable}, 32'd1);
      check({tag, "_hi_a"},     {16'd0, alu_a},      {16'd0, a[31:16]});
      check({tag, "_hi_b"},     {16'd0, alu_b},      {16'd0, bp[31:16]});
      check({tag, "_hi_c"},     {31'd0, alu_c},      {31'd0, arith & lo_sum[16]});
      check({tag, "_hi_valid"}, {31'd0, rsp_valid},  32'd0);
      tick();
      for (int i = 0; i <= hold; i++) begin
         check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
         check({tag, "_rsp_data"},  rsp_data,           exp_data);
         check({tag, "_rsp_carry"}, {31'd0, rsp_carry}, {31'd0, exp_carry});
`ifdef ALU_SEQ_OVF_EN
         check({tag, "_rsp_ovf"},   {31'd0, rsp_ovf},   {31'd0, exp_ovf});
`endif
         check({tag, "_rsp_ready"}, {31'd0, req_ready}, 32'd0);
         check({tag, "_rsp_en"},    {31'd0, alu_enable}, 32'd0);
         if (i < hold) tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 32'd0;
      req_b     = 32'd0;
      rsp_ready = 1'b0;
      #3;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_data",  rsp_data,           32'd0);
      check("rst_carry", {31'd0, rsp_carry}, 32'd0);
      check_alu_idle("rst");
`ifdef ALU_SEQ_OVF_EN
      check("rst_ovf", {31'd0, rsp_ovf}, 32'd0);
`endif
      #9 rst_n = 1'b1;
      tick();
      check_alu_idle("idle");

      run_op("add_lo_carry", 2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 0);
      run_op("add_wrap",     2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0);
      run_op("sub_borrow",   2'b01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
      run_op("add_ovf",      2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 0);
      run_op("xor",          2'b11, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1'b0, 0);
      run_op("and",          2'b10, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 0);
      run_op("sub_hold",     2'b01, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b1, 1'b0, 5);

      // Reset asserted while in HI.
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 32'h12345678;
      req_b     = 32'h11111111;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_hi_en", {31'd0, alu_enable}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_data",  rsp_data,           32'd0);
      check("mid_rst_carry", {31'd0, rsp_carry}, 32'd0);
      check_alu_idle("mid_rst");
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      run_op("add_after_rst", 2'b00, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
